// File: rtl/reg_serial_tx_if.sv
// Handshake and serial-line bundle for reg_serial_tx.
// The master drives the load request and word; the slave drives status and the line.
interface reg_serial_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              ena;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output ena,
    output data,
    input  ready,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  ena,
    input  data,
    output ready,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/reg_serial_tx.sv
// Word-serial transmitter: captures a parallel word on ena && ready and shifts it out
// LSB-first between a low start bit and a high stop bit, CLKS_PER_BIT cycles per bit.
module reg_serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  reg_serial_tx_if.slave  bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CntW-1:0]   cnt_q;
  logic [BitW-1:0]   bit_idx_q;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  logic              bit_end;
  logic [DATA_W-1:0] shreg_shifted;

  assign bit_end       = (cnt_q == CntLast);
  assign shreg_shifted = shreg_q >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q  <= 1'b0;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (bus.ena) begin
            shreg_q   <= bus.data;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= StStart;
            tx_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= StData;
            tx_q    <= shreg_q[0];
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q     <= '0;
            shreg_q   <= shreg_shifted;
            bit_idx_q <= bit_idx_q + BitW'(1);
            // tx is registered, so the next bit is presented from the shifted value
            if (bit_idx_q == BitLast) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= shreg_shifted[0];
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: doc/reg_serial_tx.md
Name: reg_serial_tx

Overview:
Word-serial transmitter that drains the 8-bit register datapath onto a single-wire serial line. It accepts a parallel word on a ready/enable handshake and captures it internally. It then shifts the word out LSB-first inside a start/stop frame, with a programmable bit period. It sits downstream of the 8-bit enable register and is the read/transmit end of that register's write path.

Parameters:
DATA_W, 8, word width in bits (>=1)
CLKS_PER_BIT, 4, clock cycles per serial bit (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
ena  input  1  load request; word accepted on a rising edge where ena && ready
data  input  DATA_W  parallel word to transmit; sampled only on the accept edge
ready  output  1  high when a new word can be accepted (IDLE state only)
tx  output  1  serial line; idles high
busy  output  1  high while a frame is in progress (START/DATA/STOP)
done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE, tx=1, ready=1, busy=0, done=0. The shift register, bit counter and period counter clear to 0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, ready=1, busy=0.
  - On an edge with ena=1: capture data into the shift register, clear the counters, go to START.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shreg[0].
  - After each CLKS_PER_BIT cycles, shift right and increment the bit index.
  - After DATA_W bits, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - done=1 during the first IDLE cycle only.
- Latency and timing:
  - tx falls in the cycle after the accept edge.
  - Frame length is (DATA_W+2)*CLKS_PER_BIT cycles.
  - With ena held high, the next word is accepted in the IDLE cycle that carries done, so the back-to-back frame period is (DATA_W+2)*CLKS_PER_BIT+1 cycles.
- ena or data changes while busy=1 are ignored; the captured word is unaffected.
- done and ready can both be 1 in the same cycle. If ena=1 in that cycle, the new word is accepted.
- Reset mid-frame: on the next edge, tx=1 and state=IDLE. The partial word is discarded and done is not pulsed.
- rst has priority over ena on the same edge; nothing is accepted.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle. The period counter never blocks.
- Counter widths: period counter $clog2(CLKS_PER_BIT+1), bit counter $clog2(DATA_W+1). There is no wrap-around within a frame.
- tx, ready, busy and done are registered outputs (glitch-free).

Test Plan:
1. Reset check: rst=1 for 2 cycles with ena=1 -> tx=1, ready=1, busy=0, done=0 throughout; no frame starts after rst drops with ena=0.
2. Single frame: data=8'b01010011, CLKS_PER_BIT=4, ena pulsed 1 cycle -> tx sequence, 4 cycles each, is 0 | 1,1,0,0,1,0,1,0 | 1. busy=1 for 40 cycles, then one done pulse, then ready=1.
3. Data change during frame: start frame with 8'hA5, change data to 8'hFF and pulse ena mid-DATA -> serial bits still match 8'hA5 (1,0,1,0,0,1,0,1). The second ena is ignored and no second frame occurs.
4. Back-to-back: ena held high with 8'h53 then 8'hC3 -> two frames. The second start bit begins exactly 41 cycles after the first; done pulses once per frame.
5. Mid-frame reset: assert rst at bit 3 of the DATA state -> tx=1 and ready=1 on the next edge, no done pulse; a following ena with 8'h0F transmits a clean full frame.
6. CLKS_PER_BIT=1, data=8'h80 -> tx pattern 0,0,0,0,0,0,0,0,1,1 over 10 cycles, then done.
